// File: rtl/ysyx_22040125_bru_pkg.sv
// Shared encodings for the branch resolution unit: b_check bit positions,
// 2-bit BHT counter states and the saturating counter step.
package ysyx_22040125_bru_pkg;

    localparam int B_BEQ  = 5;
    localparam int B_BNE  = 4;
    localparam int B_BLT  = 3;
    localparam int B_BGE  = 2;
    localparam int B_BLTU = 1;
    localparam int B_BGEU = 0;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } bht_cnt_e;

    localparam logic [1:0] CNT_RESET = CNT_WNT;

    function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != CNT_ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != CNT_SNT)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/ysyx_22040125_bru_if.sv
// ID-stage <-> branch unit bundle: prediction lookup, resolve request and
// registered resolve result with statistics counters.
interface ysyx_22040125_bru_if #(
    parameter int XLEN = 64,
    parameter int NSRC = 4
);
    logic [XLEN-1:0]      lk_pc;
    logic                 lk_taken;
    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic [XLEN-1:0]      in_pc;
    logic [XLEN-1:0]      in_imm;
    logic [NSRC*XLEN-1:0] rs1_cand;
    logic [NSRC*XLEN-1:0] rs2_cand;
    logic [NSRC-1:0]      rs1_sel;
    logic [NSRC-1:0]      rs2_sel;
    logic [5:0]           b_check;
    logic                 is_jal;
    logic                 is_jalr;
    logic [XLEN-1:0]      pred_pc;
    logic                 res_valid;
    logic                 redirect;
    logic [XLEN-1:0]      redirect_pc;
    logic                 res_taken;
    logic [31:0]          br_cnt;
    logic [31:0]          mis_cnt;

    modport master (
        output lk_pc, in_valid, stall, flush, in_pc, in_imm,
               rs1_cand, rs2_cand, rs1_sel, rs2_sel, b_check,
               is_jal, is_jalr, pred_pc,
        input  lk_taken, res_valid, redirect, redirect_pc, res_taken,
               br_cnt, mis_cnt
    );

    modport slave (
        input  lk_pc, in_valid, stall, flush, in_pc, in_imm,
               rs1_cand, rs2_cand, rs1_sel, rs2_sel, b_check,
               is_jal, is_jalr, pred_pc,
        output lk_taken, res_valid, redirect, redirect_pc, res_taken,
               br_cnt, mis_cnt
    );
endinterface

// File: rtl/ysyx_22040125_bht.sv
// Branch history table of 2-bit saturating counters: combinational lookup,
// clocked update, so a same-index lookup sees the pre-update value.
module ysyx_22040125_bht
    import ysyx_22040125_bru_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] cnt_arr [BHT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_ent
            localparam logic [IDX_W-1:0] ENT_IDX = IDX_W'(gi);
            logic [1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= CNT_RESET;
                else if (upd_en && upd_idx == ENT_IDX)
                    cnt_reg <= bht_step(cnt_reg, upd_taken);
            end

            assign cnt_arr[gi] = cnt_reg;
        end
    endgenerate

    assign lk_taken = cnt_arr[lk_idx][1];

endmodule

// File: rtl/ysyx_22040125_bru.sv
// Branch resolution unit: operand bypass select, condition evaluation,
// next-PC resolution with one-cycle registered result and BHT training.
module ysyx_22040125_bru
    import ysyx_22040125_bru_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NSRC      = 4,
    parameter int BHT_DEPTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    ysyx_22040125_bru_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [XLEN-1:0] rs1, rs2;
    logic [XLEN:0]   diff;
    logic            eq, lt, ltu;
    logic [5:0]      cond_vec;
    logic            is_jump, is_branch, taken, capture;
    logic [XLEN-1:0] target, pc_seq, actual_next;

    logic            res_valid_reg, redirect_reg, res_taken_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    logic [31:0]     br_cnt_reg, mis_cnt_reg;

    // Walk down to slot 0 so the lowest set select bit wins; empty select keeps slot 0.
    always_comb begin
        rs1 = bus.rs1_cand[0 +: XLEN];
        rs2 = bus.rs2_cand[0 +: XLEN];
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (bus.rs1_sel[i]) rs1 = bus.rs1_cand[i*XLEN +: XLEN];
            if (bus.rs2_sel[i]) rs2 = bus.rs2_cand[i*XLEN +: XLEN];
        end
    end

    // diff[XLEN] is the carry-out of rs1 - rs2: clear means a borrow, i.e. rs1 < rs2 unsigned.
    assign diff = {1'b0, rs1} + {1'b0, ~rs2} + {{XLEN{1'b0}}, 1'b1};
    assign eq   = (rs1 == rs2);
    assign ltu  = ~diff[XLEN];
    assign lt   = (rs1[XLEN-1] & ~rs2[XLEN-1])
                | (~(rs1[XLEN-1] ^ rs2[XLEN-1]) & diff[XLEN-1]);

    always_comb begin
        cond_vec         = '0;
        cond_vec[B_BEQ]  = eq;
        cond_vec[B_BNE]  = ~eq;
        cond_vec[B_BLT]  = lt;
        cond_vec[B_BGE]  = ~lt;
        cond_vec[B_BLTU] = ltu;
        cond_vec[B_BGEU] = ~ltu;
    end

    assign is_jump     = bus.is_jal | bus.is_jalr;
    assign is_branch   = ~is_jump & (|bus.b_check);
    assign taken       = is_jump | (|(bus.b_check & cond_vec));
    assign target      = bus.is_jalr ? ((rs1 + bus.in_imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                     : (bus.in_pc + bus.in_imm);
    assign pc_seq      = bus.in_pc + XLEN'(4);
    assign actual_next = taken ? target : pc_seq;
    assign capture     = bus.in_valid & ~bus.stall & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg   <= 1'b0;
            redirect_reg    <= 1'b0;
            res_taken_reg   <= 1'b0;
            redirect_pc_reg <= '0;
            br_cnt_reg      <= '0;
            mis_cnt_reg     <= '0;
        end else begin
            res_valid_reg <= capture;
            redirect_reg  <= capture && (actual_next != bus.pred_pc);
            if (capture) begin
                res_taken_reg   <= taken;
                redirect_pc_reg <= actual_next;
                if (is_branch && br_cnt_reg != 32'hFFFF_FFFF)
                    br_cnt_reg <= br_cnt_reg + 32'd1;
                if ((actual_next != bus.pred_pc) && mis_cnt_reg != 32'hFFFF_FFFF)
                    mis_cnt_reg <= mis_cnt_reg + 32'd1;
            end
        end
    end

    ysyx_22040125_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_idx    (bus.lk_pc[IDX_W+1:2]),
        .lk_taken  (bus.lk_taken),
        .upd_en    (capture & is_branch),
        .upd_idx   (bus.in_pc[IDX_W+1:2]),
        .upd_taken (taken)
    );

    assign bus.res_valid   = res_valid_reg;
    assign bus.redirect    = redirect_reg;
    assign bus.res_taken   = res_taken_reg;
    assign bus.redirect_pc = redirect_pc_reg;
    assign bus.br_cnt      = br_cnt_reg;
    assign bus.mis_cnt     = mis_cnt_reg;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.lk_pc[XLEN-1:IDX_W+2], bus.lk_pc[1:0], diff[XLEN-2:0]};

endmodule

// File: tb/tb_ysyx_22040125_bru.sv
// Directed bench for the branch resolution unit with an expected-result queue
// and an independent behavioural model of conditions, counters and the BHT.
module tb_ysyx_22040125_bru;

    localparam int XLEN = 64;
    localparam int NSRC = 4;
    localparam int BHTD = 16;

    localparam logic [5:0] BEQ  = 6'b100000;
    localparam logic [5:0] BNE  = 6'b010000;
    localparam logic [5:0] BLT  = 6'b001000;
    localparam logic [5:0] BLTU = 6'b000010;
    localparam logic [5:0] NONE = 6'b000000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22040125_bru_if #(.XLEN(XLEN), .NSRC(NSRC)) bus ();

    ysyx_22040125_bru #(.XLEN(XLEN), .NSRC(NSRC), .BHT_DEPTH(BHTD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic            taken;
        logic            redirect;
        logic [XLEN-1:0] npc;
    } exp_t;

    exp_t            sb[$];
    int              n_vec = 0;
    int              n_err = 0;
    logic [31:0]     br_m, mis_m;
    logic [1:0]      bht_m [BHTD];
    logic            last_taken;
    logic [XLEN-1:0] last_npc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHTD; i++) bht_m[i] = 2'd1;
        br_m = 0; mis_m = 0; last_taken = 1'b0; last_npc = '0;
        sb.delete();
    endtask

    task automatic check_out(input logic cap);
        exp_t e;
        chk("res_valid", {63'd0, bus.res_valid}, {63'd0, cap});
        if (cap && sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_taken", {63'd0, bus.res_taken}, {63'd0, e.taken});
            chk("redirect", {63'd0, bus.redirect}, {63'd0, e.redirect});
            chk("redirect_pc", bus.redirect_pc, e.npc);
            last_taken = e.taken;
            last_npc   = e.npc;
        end else begin
            chk("redirect_idle", {63'd0, bus.redirect}, 64'd0);
            chk("res_taken_hold", {63'd0, bus.res_taken}, {63'd0, last_taken});
            chk("redirect_pc_hold", bus.redirect_pc, last_npc);
        end
        chk("br_cnt", {32'd0, bus.br_cnt}, {32'd0, br_m});
        chk("mis_cnt", {32'd0, bus.mis_cnt}, {32'd0, mis_m});
    endtask

    // Called at posedge+1; drives one ID-stage op, checks the lookup before the
    // edge and the registered result just after it.
    task automatic apply(input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] a, input logic [63:0] b,
                         input int s1, input int s2,
                         input logic [3:0] sel1, input logic [3:0] sel2,
                         input logic [5:0] bc, input logic jal, input logic jalr,
                         input logic [63:0] pred,
                         input logic v, input logic st, input logic fl);
        logic            cap, tk, cond, br;
        logic [63:0]     nxt;
        logic [3:0]      idx;
        exp_t            e;
        for (int j = 0; j < NSRC; j++) begin
            bus.rs1_cand[j*XLEN +: XLEN] = 64'hDEAD_0000_0000_0010 + 64'(j);
            bus.rs2_cand[j*XLEN +: XLEN] = 64'hBEEF_0000_0000_0020 + 64'(j);
        end
        bus.rs1_cand[s1*XLEN +: XLEN] = a;
        bus.rs2_cand[s2*XLEN +: XLEN] = b;
        bus.rs1_sel = sel1;  bus.rs2_sel = sel2;
        bus.in_pc = pc;      bus.in_imm = imm;    bus.lk_pc = pc;
        bus.b_check = bc;    bus.is_jal = jal;    bus.is_jalr = jalr;
        bus.pred_pc = pred;  bus.in_valid = v;    bus.stall = st;  bus.flush = fl;

        idx = pc[5:2];
        #1;
        chk("lk_taken", {63'd0, bus.lk_taken}, {63'd0, bht_m[idx][1]});

        cap  = v && !st && !fl;
        cond = (bc[5] && a == b) || (bc[4] && a != b) ||
               (bc[3] && $signed(a) <  $signed(b)) || (bc[2] && $signed(a) >= $signed(b)) ||
               (bc[1] && a < b) || (bc[0] && a >= b);
        tk   = jal || jalr || cond;
        br   = !jal && !jalr && (bc != 6'd0);
        if (!tk)       nxt = pc + 64'd4;
        else if (jalr) nxt = (a + imm) & 64'hFFFF_FFFF_FFFF_FFFE;
        else           nxt = pc + imm;
        if (cap) begin
            e.taken = tk; e.redirect = (nxt != pred); e.npc = nxt;
            sb.push_back(e);
            if (br) begin
                br_m++;
                if (tk && bht_m[idx] != 2'd3) bht_m[idx] = bht_m[idx] + 2'd1;
                else if (!tk && bht_m[idx] != 2'd0) bht_m[idx] = bht_m[idx] - 2'd1;
            end
            if (nxt != pred) mis_m++;
        end

        @(posedge clk);
        #1;
        check_out(cap);
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        bus.lk_pc = '0; bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.in_pc = '0; bus.in_imm = '0; bus.rs1_cand = '0; bus.rs2_cand = '0;
        bus.rs1_sel = '0; bus.rs2_sel = '0; bus.b_check = '0;
        bus.is_jal = 1'b0; bus.is_jalr = 1'b0; bus.pred_pc = '0;
        model_reset();

        rst_n = 1'b0;
        #1;
        chk("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
        chk("rst_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // bne on equal operands: not taken, correctly predicted fall-through
        apply(64'h100, 64'h40, 64'd5, 64'd5, 0, 0, 4'b0001, 4'b0001, BNE, 0, 0, 64'h104, 1, 0, 0);
        // blt signed: -1 < 1 taken, mispredicted
        apply(64'h8000_0000, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 4'b0001, 4'b0001,
              BLT, 0, 0, 64'h8000_0004, 1, 0, 0);
        // bltu same operands: not taken
        apply(64'h8000_0000, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 4'b0001, 4'b0001,
              BLTU, 0, 0, 64'h8000_0004, 1, 0, 0);
        // jalr through bypass slot 2, bit 0 cleared
        apply(64'h200, 64'd0, 64'h1001, 64'd0, 2, 0, 4'b0100, 4'b0000, NONE, 0, 1, 64'h204, 1, 0, 0);
        // Idle cycle: result fields hold
        apply(64'h300, 64'd0, 64'd0, 64'd0, 0, 0, 4'b0001, 4'b0001, NONE, 0, 0, 64'h0, 0, 0, 0);

        // Training at 0x40: four taken then five not-taken then one taken
        for (int k = 0; k < 4; k++)
            apply(64'h40, 64'h20, 64'h7, 64'h7, 1, 1, 4'b1110, 4'b0010, BEQ, 0, 0, 64'h60, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            apply(64'h40, 64'h20, 64'h7, 64'h8, 1, 3, 4'b0010, 4'b1000, BEQ, 0, 0, 64'h60, 1, 0, 0);
        apply(64'h40, 64'h20, 64'h9, 64'h9, 0, 0, 4'b0000, 4'b0000, BEQ, 0, 0, 64'h60, 1, 0, 0);

        // Flush over valid, then stall: nothing captured, BHT untouched
        apply(64'h40, 64'h20, 64'h9, 64'h9, 0, 0, 4'b0001, 4'b0001, BEQ, 0, 0, 64'h44, 1, 0, 1);
        apply(64'h40, 64'h20, 64'h9, 64'h9, 0, 0, 4'b0001, 4'b0001, BEQ, 0, 0, 64'h44, 1, 1, 0);
        apply(64'h40, 64'h20, 64'h9, 64'h9, 0, 0, 4'b0001, 4'b0001, BEQ, 0, 0, 64'h60, 1, 0, 0);

        // PC wrap on fall-through, jal, and a non-branch with empty b_check
        apply(64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'd3, 64'd3, 0, 0, 4'b0001, 4'b0001,
              BNE, 0, 0, 64'h0, 1, 0, 0);
        apply(64'h500, 64'hFFFF_FFFF_FFFF_FF00, 64'd0, 64'd0, 0, 0, 4'b0001, 4'b0001,
              NONE, 1, 0, 64'h504, 1, 0, 0);
        apply(64'h600, 64'h10, 64'd1, 64'd2, 0, 0, 4'b0001, 4'b0001, NONE, 0, 0, 64'h604, 1, 0, 0);

        // Reset asserted while a result is live and another op is on the bus
        apply(64'h40, 64'h20, 64'h1, 64'h1, 0, 0, 4'b0001, 4'b0001, BEQ, 0, 0, 64'h44, 1, 0, 0);
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_res_valid", {63'd0, bus.res_valid}, 64'd0);
        chk("midrst_redirect", {63'd0, bus.redirect}, 64'd0);
        chk("midrst_res_taken", {63'd0, bus.res_taken}, 64'd0);
        chk("midrst_redirect_pc", bus.redirect_pc, 64'd0);
        chk("midrst_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
        chk("midrst_mis_cnt", {32'd0, bus.mis_cnt}, 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_out(1'b0);

        // First capture after reset starts counters and BHT from power-up values
        apply(64'h40, 64'h20, 64'h2, 64'h2, 0, 0, 4'b0001, 4'b0001, BEQ, 0, 0, 64'h44, 1, 0, 0);
        apply(64'h40, 64'h20, 64'h2, 64'h3, 0, 0, 4'b0001, 4'b0001, BEQ, 0, 0, 64'h44, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_bru.md
YSYX_22040125_BRU -- requirements
Module: ysyx_22040125_bru

Interface
REQ-001 SHALL have parameter XLEN, 64, datapath width in bits.
REQ-002 SHALL have parameter NSRC, 4, number of forwarding candidates per operand (>=2).
REQ-003 SHALL have parameter BHT_DEPTH, 16, BHT entries (power of 2, >=2); IDX_W = log2(BHT_DEPTH).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- lk_pc  in  XLEN  fetch PC for prediction lookup
- lk_taken  out  1  combinational prediction: MSB of counter at lk_pc[IDX_W+1:2]
- in_valid  in  1  ID-stage control-transfer instruction present
- stall  in  1  hold; no capture this cycle
- flush  in  1  kill the ID instruction and any registered result
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- rs1_cand, rs2_cand  in  NSRC*XLEN  candidates; slot 0 = register file, 1..NSRC-1 = bypass
- rs1_sel, rs2_sel  in  NSRC  one-hot candidate select
- b_check  in  6  one-hot {beq,bne,blt,bge,bltu,bgeu}, bit 5 = beq
- is_jal, is_jalr  in  1 each  unconditional jump type
- pred_pc  in  XLEN  next PC fetch used
- res_valid  out  1  registered result pulse
- redirect  out  1  registered: fetch must restart at redirect_pc
- redirect_pc  out  XLEN  registered correct next PC
- res_taken  out  1  registered resolved direction
- br_cnt, mis_cnt  out  32 each  resolved conditional branches, redirects

Function
REQ-006 SHALL select an operand by lowest set bit of its select; all-zero select SHALL pick slot 0.
REQ-007 SHALL compute beq/bne by equality and bltu/bgeu from the borrow of rs1 + ~rs2 + 1 over XLEN+1 bits.
REQ-008 SHALL compute blt as (rs1 sign & ~rs2 sign) | (signs equal & difference sign); bge = ~blt.
REQ-009 SHALL set taken = 1 for jal/jalr, else OR of b_check bits ANDed with their conditions; b_check all-zero and not a jump: taken = 0.
REQ-010 SHALL compute target = in_pc + in_imm (branch, jal) or (rs1 + in_imm) with bit 0 cleared (jalr); all sums modulo 2^XLEN.
REQ-011 SHALL compute actual_next = taken ? target : in_pc + 4, wrapping modulo 2^XLEN.
REQ-012 SHALL capture when in_valid & ~stall & ~flush, then in the next cycle assert res_valid=1, res_taken, redirect_pc=actual_next, redirect=(actual_next != pred_pc): one-cycle latency.
REQ-013 SHALL deassert res_valid and redirect in every cycle following a cycle with no capture; outputs other than res_valid/redirect SHALL hold their last values.
REQ-014 SHALL give flush priority over in_valid and stall: a flush cycle captures nothing and causes no BHT or counter update.
REQ-015 SHALL update the BHT entry at in_pc[IDX_W+1:2] on capture of a conditional branch: 2-bit saturating, +1 if taken (max 3), -1 if not (min 0); jumps SHALL NOT update it.
REQ-016 SHALL return the pre-update counter value on lk_taken when lookup and update hit one index in the same cycle.
REQ-017 SHALL increment br_cnt per captured conditional branch and mis_cnt per asserted redirect, both saturating at 0xFFFFFFFF.

Reset
REQ-018 SHALL on rst_n=0 immediately set res_valid=0, redirect=0, res_taken=0, redirect_pc=0, br_cnt=0, mis_cnt=0 and every BHT counter to 2'b01 (weakly not-taken).
REQ-019 SHALL discard any in-flight capture when reset asserts mid-operation; the first capture after deassertion SHALL behave as from power-up.

Structure
REQ-020 SHALL place b_check bit positions, counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the reset counter value in package ysyx_22040125_bru_pkg.
REQ-021 SHALL implement the BHT (counter array, lookup port, update port) as sub-module ysyx_22040125_bht.

Verification
REQ-022 bne with rs1=5, rs2=5, pred_pc=in_pc+4 -> next cycle res_valid=1, res_taken=0, redirect=0; br_cnt=1.
REQ-023 blt, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, in_pc=0x8000_0000, imm=0x10, pred_pc=0x8000_0004 -> redirect=1, redirect_pc=0x8000_0010, mis_cnt=1.
REQ-024 bltu same operands -> res_taken=0; jalr with rs1 via bypass slot 2 =0x1001, imm=0 -> redirect_pc=0x1000.
REQ-025 Four taken beq at pc 0x40 -> lk_taken at 0x40 goes 0,1,1,1 after each update; four not-taken -> counter saturates at 0.
REQ-026 in_valid with flush=1, then in_valid with stall=1 -> res_valid stays 0, counters and BHT unchanged; rst_n low mid-capture -> all outputs 0 at once.
